bmc_array: RTL
==============

Name: bmc_array

Overview:
- Parametrised Viterbi branch-metric unit. One received code pair in; path-0 and path-1 branch metrics for every trellis state out, in the same cycle.
- Replaces the per-state hard-decision metric blocks with a single generator-driven array.
- Supports soft-decision inputs and per-bit erasure for punctured codes.
- Two-stage pipeline with ready/valid flow control. Sits between the demodulator/depuncturer and the add-compare-select array.

Parameters:
- K, 4, constraint length; NS = 2^(K-1) states.
- G0, 4'b1101, generator polynomial for code bit 0 (bit K-1 = newest input).
- G1, 4'b1011, generator polynomial for code bit 1.
- SW, 3, soft sample width. SW=1 is hard decision.
- CW, 8, symbol index counter width.

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  input pair valid.
- in_ready  output  1  unit can accept a pair this cycle.
- in_sof  input  1  first symbol of a frame; qualified by in_valid.
- rx_pair  input  2*SW  [SW-1:0] = code bit 0 sample, [2SW-1:SW] = bit 1 sample. Unsigned; 0 = strong 0, 2^SW-1 = strong 1.
- erase  input  2  per-bit erasure (punctured); bit i erases sample i.
- out_valid  output  1  metrics valid.
- out_ready  input  1  downstream accepts.
- out_sof  output  1  sof aligned with the output.
- out_sym_idx  output  CW  symbol index within the frame.
- path_0_bmc  output  NS*(SW+1)  metric for input bit 0, state s at slice s.
- path_1_bmc  output  NS*(SW+1)  metric for input bit 1, state s at slice s.

Behaviour:
- Expected code bits for state s, input b: reg = {b, s[K-2:0]}; e0 = ^(reg & G0); e1 = ^(reg & G1). Computed combinationally from parameters.
- Per-bit distance with MAX = 2^SW-1: d(r,e) = e ? MAX-r : r; forced to 0 when that bit is erased.
- Metric = d(rx1,e1) + d(rx0,e0), width SW+1, no saturation needed (max 2*MAX fits).
- SW=1, no erasure: exactly the 2-bit Hamming metric.
- Pipeline:
  - Stage 1 registers rx_pair, erase, sof and valid.
  - Stage 2 registers all metrics, sof, sym_idx and valid.
  - Latency: 2 cycles from accepted input to out_valid.
- Advance enable: adv = !out_valid || out_ready. Both stages load only when adv=1, and in_ready = adv.
  - An input transfers when in_valid && in_ready.
  - Stage 1 loads valid=0 bubbles when in_valid=0.
- While out_valid && !out_ready: all outputs hold stable, in_ready=0, no data lost or duplicated.
- Symbol counter, advanced at stage-2 load of a valid entry:
  - If sof is set, the entry gets idx 0 and the counter becomes 1.
  - Otherwise the entry gets the counter value, then the counter increments.
  - Wraps 2^CW-1 -> 0 silently.
- Reset (rst_n=0 at a clk edge, including mid-stream):
  - Both stage valids = 0, counter = 0.
  - out_valid=0, out_sof=0, out_sym_idx=0, path_0_bmc=0, path_1_bmc=0.
  - in_ready=1 from the first cycle after reset.
  - In-flight pairs are discarded.
- Simultaneous out_ready and in_valid with a full pipeline: shift through, one-per-cycle throughput sustained.

Decomposition:
- Package bmc_pkg:
  - function exp_bits(state, b, G0, G1, K) returning {e1,e0}.
  - function soft_dist(r, e, erased).
  - localparams NS and MW = SW+1.
- Sub-module bmc_lane: combinational metric for one state (both branches), instantiated NS times via generate. Pipeline registers, handshake and counter stay in bmc_array.

Test Plan (all defaults: K=4, SW=3, unless noted):
- Zero pair: rx_pair={3'd0,3'd0}, erase=0, in_sof=1.
  - 2 cycles later out_valid=1, out_sof=1, out_sym_idx=0.
  - State 0: path_0=0, path_1=14 (expected 11).
- Full erasure: erase=2'b11 with any rx.
  - Every path_0/path_1 slice = 0.
- Hard-decision build (SW=1): rx_pair=2'b01.
  - State 0 path_0=1, path_1=1 (expected 11).
  - Exhaustive sweep of all states/inputs against a reference model of exp_bits plus Hamming distance.
- Backpressure: stream 5 pairs with in_valid=1 and out_ready=0 for cycles 3-5.
  - out_valid held with stable data, in_ready=0 during the stall.
  - All 5 results emerge in order with idx 0..4, no loss or duplication.
- Counter wrap (CW=4): 18 pairs, sof only on the first.
  - idx sequence 0..15, 0, 1.
  - A new sof at pair 19 gives idx 0.
- Reset mid-stream: assert rst_n=0 for 1 cycle with 2 pairs in flight.
  - All outputs 0, out_valid=0.
  - Next accepted pair appears with out_sym_idx=0 after 2 cycles.

Source files
------------

// File: rtl/bmc_pkg.sv
// -----------------------------------------------------------------------------
// bmc_pkg
// Shared definitions for the Viterbi branch-metric array.
//   NS, MW    : state count and metric width for the default configuration
//               (K=4, SW=3). Parametrised modules derive their own values.
//   exp_bits  : expected {e1,e0} code bits for a trellis state and input bit.
//   soft_dist : per-bit soft distance with erasure forcing.
// -----------------------------------------------------------------------------
package bmc_pkg;

  localparam int K_DEF  = 4;
  localparam int SW_DEF = 3;
  localparam int NS     = 1 << (K_DEF - 1);
  localparam int MW     = SW_DEF + 1;

  // Working widths wide enough for any supported generator / sample width.
  localparam int GW = 32;
  localparam int DW = 16;

  // Encoder register is {b, state[K-2:0]}; bit K-1 holds the newest input.
  function automatic logic [1:0] exp_bits(input int state, input logic b,
                                          input logic [GW-1:0] g0,
                                          input logic [GW-1:0] g1,
                                          input int k);
    logic [GW-1:0] mask;
    logic [GW-1:0] r;
    mask = (GW'(1) << (k - 1)) - GW'(1);
    r    = (GW'(state) & mask) | (GW'(b) << (k - 1));
    return {^(r & g1), ^(r & g0)};
  endfunction

  // Distance of an unsigned soft sample from the expected bit. An erased
  // (punctured) bit carries no information, so it contributes nothing.
  function automatic logic [DW-1:0] soft_dist(input logic [DW-1:0] r,
                                               input logic e,
                                               input logic erased,
                                               input int sw);
    logic [DW-1:0] mx;
    mx = (DW'(1) << sw) - DW'(1);
    if (erased) return '0;
    return e ? (mx - r) : r;
  endfunction

endpackage

// File: rtl/bmc_lane.sv
// -----------------------------------------------------------------------------
// bmc_lane
// Combinational branch metrics for a single trellis state. The expected code
// bits are elaboration-time constants derived from the generators, so each
// lane reduces to a couple of subtract/select stages and an adder per branch.
// Ports:
//   i_rx_pair  [2*SW-1:0] sample pair, [SW-1:0] = code bit 0
//   i_erase    [1:0]      per-bit erasure
//   o_path_0   [SW:0]     metric assuming input bit 0
//   o_path_1   [SW:0]     metric assuming input bit 1
// -----------------------------------------------------------------------------
module bmc_lane
  import bmc_pkg::*;
#(
  parameter int           K     = 4,
  parameter logic [K-1:0] G0    = 4'b1101,
  parameter logic [K-1:0] G1    = 4'b1011,
  parameter int           SW    = 3,
  parameter int           STATE = 0
) (
  input  logic [2*SW-1:0] i_rx_pair,
  input  logic [1:0]      i_erase,
  output logic [SW:0]     o_path_0,
  output logic [SW:0]     o_path_1
);

  localparam int L_MW = SW + 1;

  localparam logic [1:0] E_B0 = exp_bits(STATE, 1'b0, GW'(G0), GW'(G1), K);
  localparam logic [1:0] E_B1 = exp_bits(STATE, 1'b1, GW'(G0), GW'(G1), K);

  logic [DW-1:0] w_rx0;
  logic [DW-1:0] w_rx1;
  logic [SW:0]   w_d0_b0;
  logic [SW:0]   w_d1_b0;
  logic [SW:0]   w_d0_b1;
  logic [SW:0]   w_d1_b1;

  assign w_rx0 = DW'(i_rx_pair[SW-1:0]);
  assign w_rx1 = DW'(i_rx_pair[2*SW-1:SW]);

  assign w_d0_b0 = L_MW'(soft_dist(w_rx0, E_B0[0], i_erase[0], SW));
  assign w_d1_b0 = L_MW'(soft_dist(w_rx1, E_B0[1], i_erase[1], SW));
  assign w_d0_b1 = L_MW'(soft_dist(w_rx0, E_B1[0], i_erase[0], SW));
  assign w_d1_b1 = L_MW'(soft_dist(w_rx1, E_B1[1], i_erase[1], SW));

  // Each distance is at most 2^SW-1, so the SW+1 bit sum never overflows.
  assign o_path_0 = w_d1_b0 + w_d0_b0;
  assign o_path_1 = w_d1_b1 + w_d0_b1;

endmodule

// File: rtl/bmc_array.sv
// -----------------------------------------------------------------------------
// bmc_array
// Generator-driven Viterbi branch-metric unit: one received code pair in,
// path-0 / path-1 metrics for every trellis state out. Two register stages:
// stage 1 captures the pair, stage 2 captures all metrics plus frame info.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     input handshake
//   in_sof                first symbol of a frame (qualified by in_valid)
//   rx_pair [2*SW-1:0]    soft samples, [SW-1:0] = code bit 0
//   erase   [1:0]         per-bit erasure for punctured positions
//   out_valid/out_ready   output handshake
//   out_sof, out_sym_idx  frame start flag and symbol index of the output
//   path_0_bmc/path_1_bmc NS slices of SW+1 bits, state s at slice s
//
// Handshake: a transfer happens on a clock edge where valid && ready. The
// source holds valid and data until it transfers; ready may depend on the
// sink's own ready. Both stages advance together when the output register is
// empty or being drained (adv), so in_ready = adv and a stalled output holds
// every output bit stable.
// -----------------------------------------------------------------------------
module bmc_array
  import bmc_pkg::*;
#(
  parameter int           K    = 4,
  parameter logic [K-1:0] G0   = 4'b1101,
  parameter logic [K-1:0] G1   = 4'b1011,
  parameter int           SW   = 3,
  parameter int           CW   = 8,
  localparam int          L_NS = 1 << (K - 1),
  localparam int          L_MW = SW + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sof,
  input  logic [2*SW-1:0]      rx_pair,
  input  logic [1:0]           erase,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sof,
  output logic [CW-1:0]        out_sym_idx,
  output logic [L_NS*L_MW-1:0] path_0_bmc,
  output logic [L_NS*L_MW-1:0] path_1_bmc
);

  logic                 w_adv;
  logic [L_NS*L_MW-1:0] w_p0;
  logic [L_NS*L_MW-1:0] w_p1;

  logic                 r_s1_valid;
  logic                 r_s1_sof;
  logic [2*SW-1:0]      r_s1_rx;
  logic [1:0]           r_s1_erase;

  logic                 r_out_valid;
  logic                 r_out_sof;
  logic [CW-1:0]        r_out_idx;
  logic [CW-1:0]        r_cnt;
  logic [L_NS*L_MW-1:0] r_p0;
  logic [L_NS*L_MW-1:0] r_p1;

  assign w_adv    = !r_out_valid || out_ready;
  assign in_ready = w_adv;

  generate
    for (genvar s = 0; s < L_NS; s++) begin : g_lane
      bmc_lane #(
        .K     (K),
        .G0    (G0),
        .G1    (G1),
        .SW    (SW),
        .STATE (s)
      ) u_lane (
        .i_rx_pair (r_s1_rx),
        .i_erase   (r_s1_erase),
        .o_path_0  (w_p0[s*L_MW +: L_MW]),
        .o_path_1  (w_p1[s*L_MW +: L_MW])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_sof    <= 1'b0;
      r_s1_rx     <= '0;
      r_s1_erase  <= '0;
      r_out_valid <= 1'b0;
      r_out_sof   <= 1'b0;
      r_out_idx   <= '0;
      r_cnt       <= '0;
      r_p0        <= '0;
      r_p1        <= '0;
    end else if (w_adv) begin
      // Stage 1: a cycle without in_valid loads a bubble.
      r_s1_valid <= in_valid;
      r_s1_sof   <= in_valid && in_sof;
      if (in_valid) begin
        r_s1_rx    <= rx_pair;
        r_s1_erase <= erase;
      end

      // Stage 2: metrics and the symbol index follow the valid entry.
      r_out_valid <= r_s1_valid;
      r_out_sof   <= r_s1_valid && r_s1_sof;
      if (r_s1_valid) begin
        r_p0 <= w_p0;
        r_p1 <= w_p1;
        if (r_s1_sof) begin
          r_out_idx <= '0;
          r_cnt     <= CW'(1);
        end else begin
          r_out_idx <= r_cnt;
          r_cnt     <= r_cnt + 1'b1;  // wraps silently at 2^CW
        end
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_sof     = r_out_sof;
  assign out_sym_idx = r_out_idx;
  assign path_0_bmc  = r_p0;
  assign path_1_bmc  = r_p1;

endmodule
